// File: rtl/shcl_collect_if.sv
// Bus bundle for shcl_collect: result input beats from the scheduled pipeline,
// in-order result output with ready handshake, slot-release pulse and status.
interface shcl_collect_if #(
    parameter int unsigned W_HASH   = 256,
    parameter int unsigned W_IN_MEM = 6,
    parameter int unsigned W_T      = 16
);
    logic [W_HASH-1:0]   in_hash_data;
    logic [W_T-1:0]      in_ref;
    logic [W_IN_MEM-1:0] in_d_addr;
    logic                in_hash_valid;

    logic [W_HASH-1:0]   out_hash_data;
    logic [W_T-1:0]      out_ref;
    logic                out_hash_valid;
    logic                out_hash_ready;

    logic [W_IN_MEM-1:0] free_addr;
    logic                free_valid;
    logic [W_IN_MEM:0]   occ;
    logic                err_dup;

    // Scheduler / consumer side
    modport master (
        output in_hash_data, in_ref, in_d_addr, in_hash_valid, out_hash_ready,
        input  out_hash_data, out_ref, out_hash_valid, free_addr, free_valid, occ, err_dup
    );

    // Collector side
    modport slave (
        input  in_hash_data, in_ref, in_d_addr, in_hash_valid, out_hash_ready,
        output out_hash_data, out_ref, out_hash_valid, free_addr, free_valid, occ, err_dup
    );
endinterface

// File: rtl/shcl_collect.sv
// Reorder collector: results arrive out of order into scheduler-allocated slots
// and leave strictly in slot order through a single output register.
module shcl_collect #(
    parameter int unsigned W_HASH   = 256,
    parameter int unsigned W_IN_MEM = 6,
    parameter int unsigned W_T      = 16
) (
    input logic          clk,
    input logic          rst_n,
    shcl_collect_if.slave bus
);
    localparam int unsigned DEPTH = 1 << W_IN_MEM;
    localparam int unsigned W_ENT = W_HASH + W_T;

    typedef logic [W_IN_MEM-1:0] addr_t;
    typedef logic [W_IN_MEM:0]   cnt_t;

    localparam cnt_t CNT_ONE = {{W_IN_MEM{1'b0}}, 1'b1};

    // Slot storage; contents are only meaningful where the filled bit is set
    logic [W_ENT-1:0] mem [DEPTH];

    logic [DEPTH-1:0]  filled_q, filled_d;
    addr_t             head_q, head_d;
    logic              out_valid_q, out_valid_d;
    logic [W_HASH-1:0] out_data_q, out_data_d;
    logic [W_T-1:0]    out_ref_q, out_ref_d;
    addr_t             free_addr_q, free_addr_d;
    logic              free_valid_q, free_valid_d;
    cnt_t              occ_q, occ_d;
    logic              err_dup_q, err_dup_d;

    logic              wr_hit, wr_dup, load;
    logic [W_ENT-1:0]  head_ent;

    // Classify the incoming beat and decide whether the head slot moves out
    always_comb begin
        wr_hit   = bus.in_hash_valid && !filled_q[bus.in_d_addr];
        wr_dup   = bus.in_hash_valid && filled_q[bus.in_d_addr];
        load     = filled_q[head_q] && (!out_valid_q || bus.out_hash_ready);
        head_ent = mem[head_q];
    end

    // Next-state for bitmap, head pointer, output register, release pulse and status
    always_comb begin
        filled_d     = filled_q;
        head_d       = head_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_ref_d    = out_ref_q;
        free_addr_d  = free_addr_q;
        free_valid_d = load;
        occ_d        = occ_q;
        err_dup_d    = err_dup_q || wr_dup;

        if (load) begin
            filled_d[head_q] = 1'b0;
            head_d           = head_q + addr_t'(1);
            out_valid_d      = 1'b1;
            out_data_d       = head_ent[W_ENT-1:W_T];
            out_ref_d        = head_ent[W_T-1:0];
            free_addr_d      = head_q;
        end else if (bus.out_hash_ready) begin
            out_valid_d = 1'b0;
        end

        // A write can never target the slot being loaded: that slot is filled,
        // so such a write is classified as a duplicate instead.
        if (wr_hit) begin
            filled_d[bus.in_d_addr] = 1'b1;
        end

        unique case ({wr_hit, load})
            2'b10:   occ_d = occ_q + CNT_ONE;
            2'b01:   occ_d = occ_q - CNT_ONE;
            default: occ_d = occ_q;
        endcase
    end

    // Control and output state, cleared by the asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filled_q     <= '0;
            head_q       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_ref_q    <= '0;
            free_addr_q  <= '0;
            free_valid_q <= 1'b0;
            occ_q        <= '0;
            err_dup_q    <= 1'b0;
        end else begin
            filled_q     <= filled_d;
            head_q       <= head_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_ref_q    <= out_ref_d;
            free_addr_q  <= free_addr_d;
            free_valid_q <= free_valid_d;
            occ_q        <= occ_d;
            err_dup_q    <= err_dup_d;
        end
    end

    // Slot memory write; left unreset so it can map onto RAM
    always_ff @(posedge clk) begin
        if (wr_hit) begin
            mem[bus.in_d_addr] <= {bus.in_hash_data, bus.in_ref};
        end
    end

    // Drive the interface outputs from registers
    always_comb begin
        bus.out_hash_data  = out_data_q;
        bus.out_ref        = out_ref_q;
        bus.out_hash_valid = out_valid_q;
        bus.free_addr      = free_addr_q;
        bus.free_valid     = free_valid_q;
        bus.occ            = occ_q;
        bus.err_dup        = err_dup_q;
    end
endmodule

// File: tb/tb_shcl_collect.sv
// Self-checking bench for shcl_collect: directed scenarios plus a randomized
// out-of-order stream, all checked against an in-order slot scoreboard.
module tb_shcl_collect;
    localparam int unsigned W_HASH   = 256;
    localparam int unsigned W_IN_MEM = 6;
    localparam int unsigned W_T      = 16;
    localparam int unsigned DEPTH    = 64;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    shcl_collect_if #(.W_HASH(W_HASH), .W_IN_MEM(W_IN_MEM), .W_T(W_T)) bus ();

    shcl_collect #(.W_HASH(W_HASH), .W_IN_MEM(W_IN_MEM), .W_T(W_T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Scoreboard: last accepted write per slot; beat n must carry slot n mod DEPTH
    logic [W_HASH-1:0] exp_data [DEPTH];
    logic [W_T-1:0]    exp_ref  [DEPTH];
    int                acc, loads, wr_cnt, cyc, first_cyc, last_cyc;
    logic              prev_hold;
    logic [W_HASH-1:0] prev_data;
    logic [W_T-1:0]    prev_ref;
    logic              rec;  // current input beat is expected to be stored

    task automatic check(input string tag, input logic [W_HASH-1:0] got,
                         input logic [W_HASH-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Per-cycle observation, called at the falling edge
    task automatic mon();
        if (!rst_n) begin
            acc = 0; loads = 0; wr_cnt = 0; cyc = 0; first_cyc = 0; last_cyc = 0;
            prev_hold = 1'b0;
        end else begin
            cyc++;
            if (bus.free_valid) begin
                check("free_addr_seq", bus.free_addr, loads % DEPTH);
                loads++;
            end
            check("occ_count", bus.occ, wr_cnt - loads);
            if (prev_hold) begin
                check("hold_valid", bus.out_hash_valid, 1);
                check("hold_data", bus.out_hash_data, prev_data);
                check("hold_ref", bus.out_ref, prev_ref);
            end
            if (bus.out_hash_valid && bus.out_hash_ready) begin
                check("beat_data", bus.out_hash_data, exp_data[acc % DEPTH]);
                check("beat_ref", bus.out_ref, exp_ref[acc % DEPTH]);
                if (acc == 0) first_cyc = cyc;
                last_cyc = cyc;
                acc++;
            end
            prev_hold = bus.out_hash_valid && !bus.out_hash_ready;
            prev_data = bus.out_hash_data;
            prev_ref  = bus.out_ref;
            if (bus.in_hash_valid && rec) begin
                exp_data[bus.in_d_addr] = bus.in_hash_data;
                exp_ref[bus.in_d_addr]  = bus.in_ref;
                wr_cnt++;
            end
        end
    endtask

    // One clock: observe at the falling edge, return 1 time unit after the rising edge
    task automatic cycle();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int slot, input logic [W_HASH-1:0] d, input logic [W_T-1:0] r,
                       input logic keep);
        bus.in_d_addr     = W_IN_MEM'(slot);
        bus.in_hash_data  = d;
        bus.in_ref        = r;
        bus.in_hash_valid = 1'b1;
        rec               = keep;
        cycle();
        bus.in_hash_valid = 1'b0;
        rec               = 1'b0;
    endtask

    task automatic do_reset();
        rst_n              = 1'b0;
        bus.in_hash_valid  = 1'b0;
        bus.out_hash_ready = 1'b0;
        rec                = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    function automatic logic [W_HASH-1:0] rnd_data();
        logic [W_HASH-1:0] v;
        for (int i = 0; i < W_HASH / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_valid"}, bus.out_hash_valid, 0);
        check({pfx, "_free_valid"}, bus.free_valid, 0);
        check({pfx, "_err_dup"}, bus.err_dup, 0);
        check({pfx, "_occ"}, bus.occ, 0);
        check({pfx, "_data"}, bus.out_hash_data, 0);
        check({pfx, "_ref"}, bus.out_ref, 0);
        check({pfx, "_free_addr"}, bus.free_addr, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [W_HASH-1:0] d1;
        int fcnt;
        int win [8];
        int wp;
        int base;
        int j;
        int tmp;

        rst_n              = 1'b0;
        bus.in_hash_data   = '0;
        bus.in_ref         = '0;
        bus.in_d_addr      = '0;
        bus.in_hash_valid  = 1'b0;
        bus.out_hash_ready = 1'b0;
        rec                = 1'b0;
        #12;
        check_reset_vals("por");

        // Single write to slot 0 right after reset: valid two cycles later
        do_reset();
        bus.out_hash_ready = 1'b1;
        put(0, 256'hA, 16'd1, 1'b1);
        check("lat_t1_valid", bus.out_hash_valid, 0);
        cycle();
        check("lat_t2_valid", bus.out_hash_valid, 1);
        check("lat_t2_data", bus.out_hash_data, 256'hA);
        check("lat_t2_ref", bus.out_ref, 1);
        check("lat_free_valid", bus.free_valid, 1);
        check("lat_free_addr", bus.free_addr, 0);
        cycle();
        check("lat_free_pulse_len", bus.free_valid, 0);
        check("lat_t3_valid", bus.out_hash_valid, 0);

        // Reverse arrival order 3,2,1,0
        do_reset();
        bus.out_hash_ready = 1'b1;
        for (int s = 3; s >= 0; s--) begin
            put(s, rnd_data(), W_T'(100 + s), 1'b1);
            check("reo_stall", bus.out_hash_valid, 0);
        end
        check("reo_occ_peak", bus.occ, 4);
        for (int s = 0; s < 4; s++) begin
            cycle();
            check("reo_valid", bus.out_hash_valid, 1);
            check("reo_ref", bus.out_ref, 100 + s);
        end
        cycle();
        check("reo_done_valid", bus.out_hash_valid, 0);

        // Back-pressure with slots 0..2 filled
        do_reset();
        fcnt = 0;
        for (int s = 0; s < 3; s++) begin
            put(s, rnd_data(), W_T'(200 + s), 1'b1);
            fcnt += int'(bus.free_valid);
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", bus.out_hash_valid, 1);
            check("bp_ref", bus.out_ref, 200);
            check("bp_occ", bus.occ, 2);
            cycle();
            fcnt += int'(bus.free_valid);
        end
        check("bp_free_once", fcnt, 1);
        bus.out_hash_ready = 1'b1;
        for (int s = 0; s < 3; s++) begin
            check("bp_rel_valid", bus.out_hash_valid, 1);
            check("bp_rel_ref", bus.out_ref, 200 + s);
            cycle();
        end
        check("bp_rel_done", bus.out_hash_valid, 0);

        // Duplicate write to slot 5 before it drains
        do_reset();
        bus.out_hash_ready = 1'b1;
        d1 = rnd_data();
        put(5, d1, 16'h55, 1'b1);
        check("dup_first_flag", bus.err_dup, 0);
        put(5, rnd_data(), 16'h66, 1'b0);
        check("dup_flag", bus.err_dup, 1);
        for (int s = 0; s < 5; s++) put(s, rnd_data(), W_T'(s), 1'b1);
        repeat (8) cycle();
        check("dup_beats", acc, 6);
        check("dup_slot5_data", exp_data[5], d1);
        check("dup_sticky", bus.err_dup, 1);

        // 130 results in slot order: wrap and sustained throughput
        do_reset();
        bus.out_hash_ready = 1'b1;
        for (int k = 0; k < 130; k++) put(k % DEPTH, rnd_data(), W_T'(k), 1'b1);
        repeat (4) cycle();
        check("wrap_beats", acc, 130);
        check("wrap_gapless", last_cyc - first_cyc, 129);
        check("wrap_frees", loads, 130);
        check("wrap_err_dup", bus.err_dup, 0);

        // Reset in the middle of a stalled stream
        do_reset();
        for (int s = 0; s <= 10; s++) put(s, rnd_data(), W_T'(300 + s), 1'b1);
        check("mid_occ", bus.occ, 10);
        check("mid_valid", bus.out_hash_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        cycle();
        check("mid_rst_free", bus.free_valid, 0);
        cycle();
        check("mid_rst_hold_valid", bus.out_hash_valid, 0);
        rst_n              = 1'b1;
        bus.out_hash_ready = 1'b1;
        d1 = rnd_data();
        put(0, d1, 16'h77, 1'b1);
        check("mid_post_t1", bus.out_hash_valid, 0);
        cycle();
        check("mid_post_valid", bus.out_hash_valid, 1);
        check("mid_post_data", bus.out_hash_data, d1);
        check("mid_post_ref", bus.out_ref, 16'h77);

        // Randomized: shuffled windows of 8 slots, random gaps and ready
        do_reset();
        wp   = 8;
        base = 0;
        for (int c = 0; c < 3000; c++) begin
            bus.out_hash_ready = ($urandom_range(0, 9) < 7);
            if (wp == 8) begin
                for (int i = 0; i < 8; i++) win[i] = base + i;
                for (int i = 7; i > 0; i--) begin
                    j      = $urandom_range(0, i);
                    tmp    = win[i];
                    win[i] = win[j];
                    win[j] = tmp;
                end
                base += 8;
                wp    = 0;
            end
            // Slot reuse only once its previous occupant has been accepted
            if ($urandom_range(0, 9) < 6 && win[wp] < acc + DEPTH) begin
                put(win[wp] % DEPTH, rnd_data(), W_T'($urandom()), 1'b1);
                wp++;
            end else begin
                cycle();
            end
        end
        bus.out_hash_ready = 1'b1;
        while (wp < 8) begin
            if (win[wp] < acc + DEPTH) begin
                put(win[wp] % DEPTH, rnd_data(), W_T'($urandom()), 1'b1);
                wp++;
            end else begin
                cycle();
            end
        end
        for (int i = 0; i < 2000 && acc < wr_cnt; i++) cycle();
        check("rnd_drain", acc, wr_cnt);
        check("rnd_err_dup", bus.err_dup, 0);
        check("rnd_occ_end", bus.occ, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shcl_collect.md
SHCL_COLLECT -- requirements
Module: shcl_collect

Interface
REQ-001 Parameter W_HASH, default 256: result data width.
REQ-002 Parameter W_IN_MEM, default 6: slot address width; DEPTH = 2^W_IN_MEM slots.
REQ-003 Parameter W_T, default 16: reference tag width.
REQ-004 Port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port in_hash_data, input, W_HASH: result from the scheduled pipeline.
REQ-007 Port in_ref, input, W_T: tag travelling with the result.
REQ-008 Port in_d_addr, input, W_IN_MEM: slot the scheduler allocated to this result.
REQ-009 Port in_hash_valid, input, 1: input beat valid; there is no back-pressure, so every beat is taken.
REQ-010 Port out_hash_data, output, W_HASH: in-order result.
REQ-011 Port out_ref, output, W_T: tag of out_hash_data.
REQ-012 Port out_hash_valid, output, 1: output beat valid.
REQ-013 Port out_hash_ready, input, 1: downstream accepts the beat.
REQ-014 Port free_addr, output, W_IN_MEM: slot released back to the scheduler.
REQ-015 Port free_valid, output, 1: one-cycle pulse qualifying free_addr.
REQ-016 Port occ, output, W_IN_MEM+1: number of filled slots, excluding the output register.
REQ-017 Port err_dup, output, 1: sticky error flag for a write to an already-filled slot.

Function
REQ-018 Storage: DEPTH entries of {data, ref}, plus a DEPTH-bit filled bitmap and a W_IN_MEM-bit head pointer.
REQ-019 Input write, when in_hash_valid=1:
  - if filled[in_d_addr]=0 (value at cycle start): store {data, ref} in that slot and set its filled bit at the clock edge.
  - otherwise: drop the write and set err_dup=1 until reset.
REQ-020 Load condition in a cycle: filled[head]=1 AND (out_hash_valid=0 OR out_hash_ready=1).
REQ-021 On load, at the clock edge:
  - the output register takes mem[head];
  - filled[head] clears;
  - head increments modulo DEPTH;
  - free_addr takes the old head value and free_valid=1 for exactly the next cycle.
REQ-022 If no load occurs and out_hash_ready=1, out_hash_valid clears at the edge.
REQ-023 While out_hash_valid=1 and out_hash_ready=0, out_hash_data and out_ref hold stable.
REQ-024 Latency: a write to slot head in cycle t gives out_hash_valid=1 in cycle t+2.
REQ-025 Ordering: results leave strictly in slot order 0,1,…,DEPTH-1,0,… regardless of arrival order.
  - A missing head slot stalls the output even when later slots are filled.
REQ-026 Throughput: one beat per cycle is sustained when out_hash_ready=1 and the slots are pre-filled.
REQ-027 Simultaneous write and load to the same slot while it is filled is a duplicate: per REQ-019 the write is dropped and err_dup is set; the load proceeds.
REQ-028 Simultaneous write to one slot and load of another: both take effect.
REQ-029 occ = popcount(filled), registered.
  - Write only: occ increments.
  - Load only: occ decrements.
  - Both in the same cycle: occ unchanged.
REQ-030 All DEPTH slots filled: occ=DEPTH, no wrap error; any further write is a duplicate.
REQ-031 Head wrap: DEPTH-1 to 0 is seamless, with no bubble.

Reset
REQ-032 While rst_n=0:
  - out_hash_valid=0, free_valid=0, err_dup=0, occ=0;
  - head=0, filled all zero;
  - out_hash_data=0, out_ref=0, free_addr=0.
REQ-033 Reset asserted mid-operation discards all stored and in-flight results without emitting free pulses.
REQ-034 Data memory contents are not reset.
REQ-035 The first load may occur in the first cycle after rst_n deasserts.

Verification
REQ-036 In-order: write slot 0 (data=0xA, ref=1) in cycle t with out_hash_ready=1 -> out_hash_valid=1, data 0xA, ref 1 in cycle t+2; free_valid=1 with free_addr=0 in the same cycle.
REQ-037 Reorder: write slots 3,2,1,0 in consecutive cycles -> no output until slot 0 lands, then refs of slots 0,1,2,3 on four consecutive cycles; occ peaks at 4.
REQ-038 Back-pressure: out_hash_ready=0 for 5 cycles with slots 0-2 filled -> beat 0 held stable; occ=2; free_valid pulses once; on ready release, beats 0,1,2 follow back-to-back.
REQ-039 Duplicate: write slot 5 twice before it drains -> err_dup=1 from the second write on; the first data is emitted; the second is lost.
REQ-040 Wrap: stream 130 results in slot order with ready=1 (DEPTH=64) -> 130 outputs in order, free_addr wraps 63 to 0, err_dup stays 0.
REQ-041 Reset mid-stream: assert rst_n=0 with occ=10 -> all outputs return to reset values per REQ-032; after release, writing slot 0 yields output in 2 cycles.
